// File: rtl/udma_ethernet_rx_desc_ctrl.sv
// Ethernet RX descriptor controller: picks a free slot from a 4-entry descriptor ring, programs the
// uDMA RX channel, packs MAC bytes into 32-bit words and retires or drops each frame.
module udma_ethernet_rx_desc_ctrl #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int MAX_FRAME      = 1536
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr0_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr1_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr2_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr3_i,
  input  logic [3:0]                desc_full_i,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_valid_i,
  input  logic                      rx_last_i,
  input  logic                      rx_err_i,
  output logic                      rx_ready_o,
  output logic [L2_AWIDTH_NOAL-1:0] ch_startaddr_o,
  output logic [TRANS_SIZE-1:0]     ch_size_o,
  output logic                      ch_en_o,
  output logic [31:0]               data_o,
  output logic [1:0]                datasize_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [1:0]                rx_pointer_o,
  output logic [TRANS_SIZE-1:0]     rx_size_o,
  output logic                      drop_o,
  output logic [2:0]                state_o
);

  // Handshake: a byte moves when rx_valid_i && rx_ready_o at a rising edge; a word moves when
  // valid_o && ready_i at a rising edge. valid_o and data_o hold until that edge.

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RECV  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4,
    ST_DROP  = 3'd5
  } state_e;

  localparam logic [TRANS_SIZE-1:0] MAX_CNT = TRANS_SIZE'(MAX_FRAME);

  state_e                    state_q, state_d;
  logic [1:0]                slot_q, slot_d;
  logic [TRANS_SIZE-1:0]     cnt_q, cnt_d;
  logic [23:0]               pack_q, pack_d;
  logic [1:0]                pack_cnt_q, pack_cnt_d;
  logic [31:0]               out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic [1:0]                ptr_q, ptr_d;
  logic [TRANS_SIZE-1:0]     size_q, size_d;
  logic [L2_AWIDTH_NOAL-1:0] ch_addr_q, ch_addr_d;
  logic [TRANS_SIZE-1:0]     ch_size_q, ch_size_d;
  logic                      drop_q, drop_d;

  logic                      rx_ready_c;
  logic                      byte_acc;
  logic                      out_free;
  logic [1:0]                slot_nxt;
  logic [L2_AWIDTH_NOAL-1:0] slot_addr;
  logic [TRANS_SIZE-1:0]     cnt_inc;

  assign slot_nxt = ptr_q + 2'd1;
  assign cnt_inc  = cnt_q + 1'b1;
  assign out_free = ~out_valid_q | ready_i;

  always_comb begin
    slot_addr = cfg_rx_startaddr0_i;
    case (slot_nxt)
      2'd1:    slot_addr = cfg_rx_startaddr1_i;
      2'd2:    slot_addr = cfg_rx_startaddr2_i;
      2'd3:    slot_addr = cfg_rx_startaddr3_i;
      default: slot_addr = cfg_rx_startaddr0_i;
    endcase
  end

  // In RECV, stall only when a fourth byte would complete a word with nowhere to put it.
  always_comb begin
    rx_ready_c = 1'b0;
    if (state_q == ST_RECV) begin
      rx_ready_c = ~((pack_cnt_q == 2'd3) & ~out_free);
    end else if (state_q == ST_DROP) begin
      rx_ready_c = 1'b1;
    end
  end

  assign byte_acc = rx_valid_i & rx_ready_c;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~ready_i;
    ptr_d       = ptr_q;
    size_d      = size_q;
    ch_addr_d   = ch_addr_q;
    ch_size_d   = ch_size_q;
    drop_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_i && rx_valid_i) begin
          slot_d = slot_nxt;
          if (desc_full_i[slot_nxt]) begin
            state_d = ST_DROP;
            drop_d  = 1'b1;
          end else begin
            state_d   = ST_ARM;
            ch_addr_d = slot_addr;
            ch_size_d = MAX_CNT;
          end
        end
      end

      ST_ARM: begin
        cnt_d      = '0;
        pack_d     = '0;
        pack_cnt_d = '0;
        state_d    = ST_RECV;
      end

      ST_RECV: begin
        if (byte_acc) begin
          cnt_d = cnt_inc;
          if (rx_last_i && rx_err_i) begin
            pack_d     = '0;
            pack_cnt_d = '0;
            drop_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            pack_cnt_d = pack_cnt_q + 2'd1;
            case (pack_cnt_q)
              2'd0: pack_d[7:0]   = rx_data_i;
              2'd1: pack_d[15:8]  = rx_data_i;
              2'd2: pack_d[23:16] = rx_data_i;
              default: begin
                out_data_d  = {rx_data_i, pack_q};
                out_valid_d = 1'b1;
                pack_d      = '0;
              end
            endcase
            if (rx_last_i) begin
              state_d = ST_FLUSH;
            end else if (cnt_inc == MAX_CNT) begin
              pack_d     = '0;
              pack_cnt_d = '0;
              drop_d     = 1'b1;
              state_d    = ST_DROP;
            end
          end
        end
      end

      // Unused upper bytes of pack_q are already zero, so the tail word is naturally padded.
      ST_FLUSH: begin
        if (pack_cnt_q != 2'd0) begin
          if (out_free) begin
            out_data_d  = {8'h00, pack_q};
            out_valid_d = 1'b1;
            pack_d      = '0;
            pack_cnt_d  = '0;
          end
        end else if (!out_valid_q || ready_i) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        ptr_d   = slot_q;
        size_d  = cnt_q;
        state_d = ST_IDLE;
      end

      ST_DROP: begin
        if (byte_acc && rx_last_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      slot_q      <= 2'd0;
      cnt_q       <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= 2'b11;
      size_q      <= '0;
      ch_addr_q   <= '0;
      ch_size_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      size_q      <= size_d;
      ch_addr_q   <= ch_addr_d;
      ch_size_q   <= ch_size_d;
      drop_q      <= drop_d;
    end
  end

  assign rx_ready_o     = rx_ready_c;
  assign ch_startaddr_o = ch_addr_q;
  assign ch_size_o      = ch_size_q;
  assign ch_en_o        = (state_q == ST_ARM);
  assign data_o         = out_data_q;
  assign datasize_o     = 2'b10;
  assign valid_o        = out_valid_q;
  assign rx_pointer_o   = ptr_q;
  assign rx_size_o      = size_q;
  assign drop_o         = drop_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_udma_ethernet_rx_desc_ctrl.sv
// Bench for udma_ethernet_rx_desc_ctrl: byte-stream driver, word and channel-arm scoreboards,
// descriptor pointer model and a one-line summary.
module tb_udma_ethernet_rx_desc_ctrl;

  localparam int AW = 12;
  localparam int TS = 16;
  localparam int MF = 1536;

  localparam int M_GOOD = 0;
  localparam int M_ERR  = 1;
  localparam int M_OVF  = 2;
  localparam int M_FULL = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic [AW-1:0] sa [4];
  logic [3:0]    desc_full_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i, rx_last_i, rx_err_i;
  logic          rx_ready_o;
  logic [AW-1:0] ch_startaddr_o;
  logic [TS-1:0] ch_size_o;
  logic          ch_en_o;
  logic [31:0]   data_o;
  logic [1:0]    datasize_o;
  logic          valid_o;
  logic          ready_i;
  logic [1:0]    rx_pointer_o;
  logic [TS-1:0] rx_size_o;
  logic          drop_o;
  logic [2:0]    state_o;

  udma_ethernet_rx_desc_ctrl #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .MAX_FRAME(MF)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .cfg_rx_startaddr0_i(sa[0]), .cfg_rx_startaddr1_i(sa[1]),
    .cfg_rx_startaddr2_i(sa[2]), .cfg_rx_startaddr3_i(sa[3]),
    .desc_full_i(desc_full_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_last_i(rx_last_i), .rx_err_i(rx_err_i),
    .rx_ready_o(rx_ready_o),
    .ch_startaddr_o(ch_startaddr_o), .ch_size_o(ch_size_o), .ch_en_o(ch_en_o),
    .data_o(data_o), .datasize_o(datasize_o), .valid_o(valid_o), .ready_i(ready_i),
    .rx_pointer_o(rx_pointer_o), .rx_size_o(rx_size_o), .drop_o(drop_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            drop_cnt = 0;
  int            arm_cnt = 0;
  int            bp_seen = 0;
  int            exp_drops = 0;
  int            exp_arms = 0;
  logic [1:0]    exp_ptr = 2'b11;
  logic [TS-1:0] exp_size = '0;
  bit            sb_en = 1'b1;
  bit            ch_en_prev = 1'b0;
  bit            hold_v = 1'b0;
  logic [31:0]   hold_d = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_o && ready_i && sb_en) begin
        check_val("word_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_val("word", data_o, exp_q.pop_front());
        check_val("datasize", 32'(datasize_o), 32'd2);
      end
      if (valid_o && !ready_i && hold_v) check_val("hold", data_o, hold_d);
      hold_v = valid_o && !ready_i;
      hold_d = data_o;
      if (ch_en_o) begin
        arm_cnt++;
        check_val("ch_en_pulse", 32'(ch_en_prev), 32'd0);
        check_val("arm_avail", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) check_val("ch_addr", 32'(ch_startaddr_o), 32'(exp_addr_q.pop_front()));
        check_val("ch_size", 32'(ch_size_o), 32'(MF));
      end
      ch_en_prev = ch_en_o;
      if (drop_o) drop_cnt++;
      if (!ready_i && rx_valid_i && !rx_ready_o && state_o == 3'd2) bp_seen++;
    end else begin
      hold_v     = 1'b0;
      ch_en_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_byte(input logic [7:0] d, input logic last, input logic err);
    int  wait_n = 0;
    bit  ok = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    rx_last_i  = last;
    rx_err_i   = err;
    while (!ok && wait_n < 400) begin
      @(negedge clk);
      ok = rx_ready_o;
      @(posedge clk);
      #1;
      wait_n++;
    end
    check_val("byte_accept", 32'(ok), 32'd1);
    rx_valid_i = 1'b0;
    rx_last_i  = 1'b0;
    rx_err_i   = 1'b0;
  endtask

  task automatic send_frame(input int len, input int mode);
    logic [7:0]  b[$];
    logic [31:0] w;
    logic [1:0]  nslot;
    int          e;
    nslot = exp_ptr + 2'd1;
    for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
    case (mode)
      M_GOOD:  e = len;
      M_ERR:   e = 4 * ((len - 1) / 4);
      M_OVF:   e = 4 * (MF / 4);
      default: e = 0;
    endcase
    for (int k = 0; 4 * k < e; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) if (4 * k + j < e) w[8*j +: 8] = b[4*k+j];
      if (sb_en) exp_q.push_back(w);
    end
    if (mode != M_FULL) begin
      exp_addr_q.push_back(sa[nslot]);
      exp_arms++;
    end
    if (mode != M_GOOD) exp_drops++;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      drive_byte(b[i], 1'(i == len - 1), 1'((mode == M_ERR) && (i == len - 1)));
    end
    repeat (12) @(posedge clk);
    #1;
    if (mode == M_GOOD) begin
      exp_ptr  = nslot;
      exp_size = TS'(len);
    end
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check_val({tag, "_ptr"}, 32'(rx_pointer_o), 32'(exp_ptr));
    check_val({tag, "_size"}, 32'(rx_size_o), 32'(exp_size));
    check_val({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_arms_left"}, 32'(exp_addr_q.size()), 32'd0);
    check_val({tag, "_drops"}, 32'(drop_cnt), 32'(exp_drops));
    check_val({tag, "_arms"}, 32'(arm_cnt), 32'(exp_arms));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    check_val({tag, "_ptr"}, 32'(rx_pointer_o), 32'd3);
    check_val({tag, "_size"}, 32'(rx_size_o), 32'd0);
    check_val({tag, "_valid"}, 32'(valid_o), 32'd0);
    check_val({tag, "_data"}, data_o, 32'd0);
    check_val({tag, "_rx_ready"}, 32'(rx_ready_o), 32'd0);
    check_val({tag, "_ch_en"}, 32'(ch_en_o), 32'd0);
    check_val({tag, "_ch_addr"}, 32'(ch_startaddr_o), 32'd0);
    check_val({tag, "_ch_size"}, 32'(ch_size_o), 32'd0);
    check_val({tag, "_drop"}, 32'(drop_o), 32'd0);
    check_val({tag, "_state"}, 32'(state_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sa[0] = 12'h100; sa[1] = 12'h340; sa[2] = 12'h580; sa[3] = 12'h7C0;
    rst_i = 1'b1; en_i = 1'b1; desc_full_i = 4'b0000; ready_i = 1'b1;
    rx_data_i = '0; rx_valid_i = 1'b0; rx_last_i = 1'b0; rx_err_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // Slot 0 owned by software: whole frame discarded, no channel arm.
    desc_full_i = 4'b0001;
    send_frame(10, M_FULL);
    check_status("full0");
    desc_full_i = 4'b0000;

    send_frame(64, M_GOOD);
    check_status("f64");
    send_frame(61, M_GOOD);
    check_status("f61");
    send_frame(7, M_GOOD);
    check_status("f7");
    send_frame(1, M_GOOD);
    check_status("f1");

    // Errored frame keeps the slot; the next good frame re-arms the same address.
    send_frame(13, M_ERR);
    check_status("err");
    send_frame(20, M_GOOD);
    check_status("after_err");

    // Output stalled mid-frame: bytes must back up, not be lost.
    fork
      send_frame(100, M_GOOD);
      begin
        repeat (30) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (20) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    check_status("stall");
    check_val("backpressure_seen", 32'(bp_seen != 0), 32'd1);

    desc_full_i = 4'b0100;
    send_frame(5, M_FULL);
    check_status("full2");
    desc_full_i = 4'b0000;

    send_frame(MF + 10, M_OVF);
    check_status("ovf");

    // Disabled receive path ignores offered bytes.
    en_i = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i = 8'hA5;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_val("dis_state", 32'(state_o), 32'd0);
    check_val("dis_ready", 32'(rx_ready_o), 32'd0);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
    en_i = 1'b1;
    check_status("dis");

    // Reset mid-frame abandons it; a fresh frame starts again at slot 0.
    sb_en = 1'b0;
    exp_addr_q.push_back(sa[exp_ptr + 2'd1]);
    exp_arms++;
    for (int i = 0; i < 12; i++) drive_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    rx_valid_i = 1'b1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
    check_reset("midrst");
    rst_i = 1'b0;
    exp_ptr = 2'b11;
    exp_size = '0;
    sb_en = 1'b1;
    @(posedge clk);
    #1;
    send_frame(9, M_GOOD);
    check_status("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
